// File: rtl/lectura_rtc_pkg.sv
// Shared types and constants for the RTC read sequencer: FSM encoding,
// register counts, chip-select bit positions and the RTC address table.
package lectura_rtc_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SOLICITAR = 2'd1,
        ESCRIBIR  = 2'd2,
        FIN       = 2'd3
    } estado_t;

    localparam int N_REG_HORA  = 7;
    localparam int N_REG_TIMER = 3;
    localparam int N_REG_MAX   = N_REG_HORA + N_REG_TIMER;

    // Chip-select bit positions; the sweep index equals the bit position.
    localparam int CS_SEG_HORA   = 0;
    localparam int CS_MIN_HORA   = 1;
    localparam int CS_HORA_HORA  = 2;
    localparam int CS_DIA        = 3;
    localparam int CS_MES        = 4;
    localparam int CS_ANIO       = 5;
    localparam int CS_DIA_SEMANA = 6;
    localparam int CS_SEG_TIMER  = 7;
    localparam int CS_MIN_TIMER  = 8;
    localparam int CS_HORA_TIMER = 9;

    function automatic logic [7:0] dir_registro(input logic [3:0] idx);
        logic [7:0] dir;
        dir = 8'h00;
        case (int'(idx))
            CS_SEG_HORA:   dir = 8'h21;
            CS_MIN_HORA:   dir = 8'h22;
            CS_HORA_HORA:  dir = 8'h23;
            CS_DIA:        dir = 8'h24;
            CS_MES:        dir = 8'h25;
            CS_ANIO:       dir = 8'h26;
            CS_DIA_SEMANA: dir = 8'h27;
            CS_SEG_TIMER:  dir = 8'h41;
            CS_MIN_TIMER:  dir = 8'h42;
            CS_HORA_TIMER: dir = 8'h43;
            default:       dir = 8'h00;
        endcase
        return dir;
    endfunction

    function automatic logic [N_REG_MAX-1:0] cs_onehot(input logic [3:0] idx);
        logic [N_REG_MAX-1:0] v;
        v = '0;
        if (int'(idx) < N_REG_MAX) begin
            v[idx] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/secuenciador_lectura_rtc_if.sv
// Read-request bus between the sequencer (master) and the RTC bus driver (slave).
interface secuenciador_lectura_rtc_if;
    // rd_req rises with rd_addr and both hold until the cycle rd_ack is sampled
    // high; rd_data is valid only in that rd_ack cycle. rd_ack with rd_req low
    // carries no meaning and is ignored by the master.
    logic       rd_req;
    logic [7:0] rd_addr;
    logic       rd_ack;
    logic [7:0] rd_data;

    modport master (
        output rd_req,
        output rd_addr,
        input  rd_ack,
        input  rd_data
    );

    modport slave (
        input  rd_req,
        input  rd_addr,
        output rd_ack,
        output rd_data
    );
endinterface

// File: rtl/contador_timeout.sv
// 8-bit wait counter: cleared outside the request phase, counts while enabled,
// flags the last allowed cycle so the FSM can give up on the same edge.
module contador_timeout #(
    parameter int LIMITE = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic fin_o
);

    logic [7:0] cnt_q, cnt_d;

    assign fin_o = en_i && (cnt_q == 8'(LIMITE - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !fin_o) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/secuenciador_lectura_rtc.sv
// RTC read sequencer: on a tick, reads each RTC register in turn and pulses the
// matching chip select with the latched byte. Timer registers only with LECTURA_TIMER_EN.
module secuenciador_lectura_rtc
    import lectura_rtc_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tick_lectura,
    input  logic                          inhibir,
    secuenciador_lectura_rtc_if.master    bus,
    output logic [7:0]                    dato_rtc,
    output logic [9:0]                    cs_vec,
    output logic                          ocupado,
    output logic                          lectura_completa,
    output logic                          error_lectura,
    output estado_t                       estado_dbg
);

`ifdef LECTURA_TIMER_EN
    localparam int N_REG = N_REG_HORA + N_REG_TIMER;
`else
    localparam int N_REG = N_REG_HORA;
`endif
    localparam logic [3:0] ULTIMO = 4'(N_REG - 1);

    estado_t          estado_q;
    logic [3:0]       indice_q;
    logic             rd_req_q;
    logic [7:0]       rd_addr_q;
    logic [7:0]       dato_q;
    logic [N_REG-1:0] cs_q;
    logic             ocupado_q;
    logic             completa_q;
    logic             error_q;
    logic             abortar_q;
    logic             fin_espera;

    contador_timeout #(
        .LIMITE (TIMEOUT_CICLOS)
    ) u_timeout (
        .clk   (clk),
        .reset (reset),
        .clr_i (estado_q != SOLICITAR),
        .en_i  (estado_q == SOLICITAR),
        .fin_o (fin_espera)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q   <= IDLE;
            indice_q   <= '0;
            rd_req_q   <= 1'b0;
            rd_addr_q  <= 8'h00;
            dato_q     <= 8'h00;
            cs_q       <= '0;
            ocupado_q  <= 1'b0;
            completa_q <= 1'b0;
            error_q    <= 1'b0;
            abortar_q  <= 1'b0;
        end else begin
            cs_q       <= '0;
            completa_q <= 1'b0;
            case (estado_q)
                IDLE: begin
                    if (tick_lectura && !inhibir) begin
                        estado_q  <= SOLICITAR;
                        indice_q  <= '0;
                        rd_req_q  <= 1'b1;
                        rd_addr_q <= dir_registro(4'd0);
                        ocupado_q <= 1'b1;
                        error_q   <= 1'b0;
                        abortar_q <= 1'b0;
                    end
                end
                SOLICITAR: begin
                    // Any sight of inhibir during the wait dooms the rest of the sweep.
                    if (inhibir) begin
                        abortar_q <= 1'b1;
                    end
                    if (bus.rd_ack) begin
                        dato_q   <= bus.rd_data;
                        rd_req_q <= 1'b0;
                        estado_q <= ESCRIBIR;
                        if (!inhibir && !abortar_q) begin
                            cs_q <= N_REG'(cs_onehot(indice_q));
                        end
                    end else if (fin_espera) begin
                        error_q  <= 1'b1;
                        rd_req_q <= 1'b0;
                        estado_q <= ESCRIBIR;
                    end
                end
                ESCRIBIR: begin
                    if (abortar_q || inhibir) begin
                        estado_q  <= IDLE;
                        ocupado_q <= 1'b0;
                    end else if (indice_q == ULTIMO) begin
                        estado_q   <= FIN;
                        completa_q <= 1'b1;
                    end else begin
                        estado_q  <= SOLICITAR;
                        indice_q  <= indice_q + 4'd1;
                        rd_req_q  <= 1'b1;
                        rd_addr_q <= dir_registro(indice_q + 4'd1);
                    end
                end
                FIN: begin
                    estado_q  <= IDLE;
                    ocupado_q <= 1'b0;
                end
                default: begin
                    estado_q  <= IDLE;
                    ocupado_q <= 1'b0;
                    rd_req_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rd_req       = rd_req_q;
    assign bus.rd_addr      = rd_addr_q;
    assign dato_rtc         = dato_q;
    assign cs_vec           = 10'(cs_q);
    assign ocupado          = ocupado_q;
    assign lectura_completa = completa_q;
    assign error_lectura    = error_q;
    assign estado_dbg       = estado_q;

endmodule

// File: doc/secuenciador_lectura_rtc.md
SECUENCIADOR_LECTURA_RTC -- requirements
Module: secuenciador_lectura_rtc

Interface
REQ-001 Parameter: TIMEOUT_CICLOS, default 64, cycles to wait for rd_ack before abandoning a register read (legal 1..255).
REQ-002 clk  input  1  single system clock, all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 tick_lectura  input  1  one-cycle pulse requesting a full RTC read sweep.
REQ-005 inhibir  input  1  high while user edits values (count path owns registers); blocks reads.
REQ-006 rd_req  output  1  bus read request to RTC bus driver.
REQ-007 rd_addr  output  8  RTC register address for current request.
REQ-008 rd_ack  input  1  bus driver completion; rd_data valid in same cycle.
REQ-009 rd_data  input  8  byte read from RTC.
REQ-010 dato_rtc  output  8  latched byte, fans out to all rtc_* inputs of register memory.
REQ-011 cs_vec  output  10  one-hot chip-select pulse; bit0 seg_hora..bit6 dia_semana, bit7 seg_timer, bit8 min_timer, bit9 hora_timer.
REQ-012 ocupado  output  1  high from sweep start until return to IDLE.
REQ-013 lectura_completa  output  1  one-cycle pulse at end of an uninterrupted sweep.
REQ-014 error_lectura  output  1  sticky flag, set on any timeout in current sweep.

Function
REQ-015 FSM states IDLE, SOLICITAR, ESCRIBIR, FIN; register index 0..N-1 (N=10, or 7 per REQ-029).
REQ-016 IDLE: tick_lectura=1 and inhibir=0 -> index=0, error_lectura cleared, SOLICITAR next cycle; tick ignored (not queued) when inhibir=1 or FSM not IDLE.
REQ-017 SOLICITAR: rd_req=1, rd_addr=table[index], both stable until exit; timeout counter cleared on entry.
REQ-018 rd_ack=1 in SOLICITAR -> dato_rtc<=rd_data, rd_req low next cycle, go ESCRIBIR; rd_ack outside SOLICITAR ignored.
REQ-019 Counter reaching TIMEOUT_CICLOS without ack -> error_lectura<=1, dato_rtc unchanged, go ESCRIBIR with cs suppressed.
REQ-020 ESCRIBIR: cs_vec[index]=1 for exactly one cycle (only if ack received and inhibir=0), dato_rtc valid that cycle; then index+1 -> SOLICITAR, or FIN after last index.
REQ-021 Latency: tick at cycle 0 -> rd_req at 1; ack at cycle k -> cs at k+1 -> next rd_req at k+2; zero-wait sweep of 10 regs: last cs at cycle 20, lectura_completa at 21.
REQ-022 FIN: lectura_completa=1 one cycle, ocupado low next cycle, back to IDLE.
REQ-023 inhibir rising mid-sweep: current transaction finishes (ack or timeout), its cs suppressed, FSM returns to IDLE without FIN; no lectura_completa.
REQ-024 cs_vec never has more than one bit set; all zero outside ESCRIBIR.

Reset
REQ-025 reset low asserts immediately regardless of clk: FSM IDLE, index 0, rd_req 0, rd_addr 0x00, dato_rtc 0x00, cs_vec 0, ocupado 0, lectura_completa 0, error_lectura 0.
REQ-026 Reset mid-sweep aborts without further cs pulses; first tick after release starts at index 0.

Configuration
REQ-027 Macro LECTURA_TIMER_EN selects timer register read-back.
REQ-028 Defined: N=10, sweep includes seg/min/hora timer (indices 7..9).
REQ-029 Undefined: N=7, cs_vec[9:7] tied 0, sweep ends after dia_semana; zero-wait lectura_completa at cycle 15.

Structure
REQ-030 Package lectura_rtc_pkg: state encoding, N_REG_HORA=7, N_REG_TIMER=3, address table (0x21..0x27 seg_hora..dia_semana, 0x41..0x43 seg/min/hora timer), cs bit index constants.
REQ-031 One sub-module contador_timeout: 8-bit counter with clear, enable, terminal-count output.

Verification
REQ-032 Zero-wait ack, LECTURA_TIMER_EN defined, rd_data=0x10+index -> cs bits 0..9 in order, dato_rtc 0x10..0x19 on each pulse, lectura_completa at cycle 21.
REQ-033 rd_ack withheld at index 3, TIMEOUT_CICLOS=4 -> rd_req drops after 4 cycles, cs_vec[3] never pulses, error_lectura=1, sweep still completes; next tick clears flag.
REQ-034 inhibir=1 with tick -> no rd_req, ocupado stays 0; inhibir raised during index 5 ack wait -> no cs_vec[5], IDLE, no lectura_completa.
REQ-035 tick pulses during sweep -> ignored, exactly one sweep observed.
REQ-036 reset low while rd_req high at index 8 -> all outputs 0 same cycle; after release, tick restarts at rd_addr 0x21.
REQ-037 LECTURA_TIMER_EN undefined, zero-wait -> seven cs pulses, cs_vec[9:7] always 0, lectura_completa at cycle 15.
